// File: rtl/paddle_key_decoder.sv
// PS/2 key events to registered paddle, pause and serve controls.
// Optional KEY_WATCHDOG_EN clears held keys after WDOG_CYCLES idle clocks.
module paddle_key_decoder #(
  parameter logic [15:0] KEY_P1_UP   = 16'hE027,
  parameter logic [15:0] KEY_P1_DN   = 16'hE01F,
  parameter logic [15:0] KEY_P2_UP   = 16'hE075,
  parameter logic [15:0] KEY_P2_DN   = 16'hE072,
  parameter logic [15:0] KEY_PAUSE   = 16'h004D,
  parameter logic [15:0] KEY_SERVE   = 16'h005A,
  parameter int unsigned WDOG_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [15:0] scan_code,
  input  logic        finished,
  input  logic        break_code,
  output logic        p1_up,
  output logic        p1_down,
  output logic        p2_up,
  output logic        p2_down,
  output logic        paused,
  output logic        serve,
  output logic [7:0]  last_key
);

  // player state packed as {held_up, held_dn, pri}
  function automatic logic [2:0] trk(
    input logic [2:0] s,
    input logic       up_k,
    input logic       dn_k,
    input logic       brk
  );
    logic u, d, p;
    {u, d, p} = s;
    if (up_k) begin
      if (!brk) begin
        if (!u) begin
          u = 1'b1;
          p = 1'b0;
        end
      end else if (u) begin
        u = 1'b0;
        if (d) p = 1'b1;
      end
    end
    if (dn_k) begin
      if (!brk) begin
        if (!d) begin
          d = 1'b1;
          p = 1'b1;
        end
      end else if (d) begin
        d = 1'b0;
        if (u) p = 1'b0;
      end
    end
    return {u, d, p};
  endfunction

  logic [2:0] p1_q, p1_d, p2_q, p2_d;
  logic       paused_q, paused_d;
  logic       pause_held_q, pause_held_d;
  logic       serve_held_q, serve_held_d;
  logic       serve_q, serve_d;
  logic [7:0] last_key_q, last_key_d;
  logic [3:0] dir_q, dir_d;
  logic k_p1u, k_p1d, k_p2u, k_p2d, k_pau, k_srv, k_any;

`ifdef KEY_WATCHDOG_EN
  localparam int WdW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(WDOG_CYCLES);
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
`endif

  always_comb begin
    k_p1u = (scan_code == KEY_P1_UP);
    k_p1d = (scan_code == KEY_P1_DN);
    k_p2u = (scan_code == KEY_P2_UP);
    k_p2d = (scan_code == KEY_P2_DN);
    k_pau = (scan_code == KEY_PAUSE);
    k_srv = (scan_code == KEY_SERVE);
    k_any = k_p1u | k_p1d | k_p2u | k_p2d | k_pau | k_srv;

    p1_d = trk(p1_q, finished & k_p1u, finished & k_p1d, break_code);
    p2_d = trk(p2_q, finished & k_p2u, finished & k_p2d, break_code);

    paused_d     = paused_q;
    pause_held_d = pause_held_q;
    if (finished && k_pau) begin
      if (!break_code) begin
        if (!pause_held_q) begin
          paused_d     = !paused_q;
          pause_held_d = 1'b1;
        end
      end else begin
        pause_held_d = 1'b0;
      end
    end

    serve_d      = 1'b0;
    serve_held_d = serve_held_q;
    if (finished && k_srv) begin
      if (!break_code) begin
        serve_d      = !serve_held_q && !paused_q;
        serve_held_d = 1'b1;
      end else begin
        serve_held_d = 1'b0;
      end
    end

    last_key_d = last_key_q;
    if (finished && !break_code && k_any) last_key_d = scan_code[7:0];

`ifdef KEY_WATCHDOG_EN
    if (finished) wd_cnt_d = '0;
    else if (wd_cnt_q == WdMax) wd_cnt_d = wd_cnt_q;
    else wd_cnt_d = wd_cnt_q + 1'b1;
    // a lost break code would otherwise pin a paddle forever
    if (!finished && wd_cnt_d == WdMax) begin
      p1_d         = 3'b000;
      p2_d         = 3'b000;
      pause_held_d = 1'b0;
      serve_held_d = 1'b0;
    end
`endif

    dir_d[3] = !paused_d & p1_d[2] & (!p1_d[1] | !p1_d[0]);
    dir_d[2] = !paused_d & p1_d[1] & (!p1_d[2] |  p1_d[0]);
    dir_d[1] = !paused_d & p2_d[2] & (!p2_d[1] | !p2_d[0]);
    dir_d[0] = !paused_d & p2_d[1] & (!p2_d[2] |  p2_d[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      p1_q         <= '0;
      p2_q         <= '0;
      paused_q     <= 1'b0;
      pause_held_q <= 1'b0;
      serve_held_q <= 1'b0;
      serve_q      <= 1'b0;
      last_key_q   <= '0;
      dir_q        <= '0;
    end else begin
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      paused_q     <= paused_d;
      pause_held_q <= pause_held_d;
      serve_held_q <= serve_held_d;
      serve_q      <= serve_d;
      last_key_q   <= last_key_d;
      dir_q        <= dir_d;
    end
  end

`ifdef KEY_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rst_b) wd_cnt_q <= '0;
    else wd_cnt_q <= wd_cnt_d;
  end
`endif

  assign p1_up    = dir_q[3];
  assign p1_down  = dir_q[2];
  assign p2_up    = dir_q[1];
  assign p2_down  = dir_q[0];
  assign paused   = paused_q;
  assign serve    = serve_q;
  assign last_key = last_key_q;

endmodule

// File: tb/tb_paddle_key_decoder.sv
// Directed-vector scoreboard bench for paddle_key_decoder.
// Build with KEY_WATCHDOG_EN to exercise the idle watchdog at WDOG_CYCLES=100.
module tb_paddle_key_decoder;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [15:0] scan_code = '0;
  logic        finished = 1'b0;
  logic        break_code = 1'b0;
  logic        p1_up, p1_down, p2_up, p2_down, paused, serve;
  logic [7:0]  last_key;

`ifdef KEY_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  paddle_key_decoder #(.WDOG_CYCLES(100)) dut (
    .clk(clk), .rst_b(rst_b), .scan_code(scan_code),
    .finished(finished), .break_code(break_code),
    .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down),
    .paused(paused), .serve(serve), .last_key(last_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [13:0] exp;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int vid = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compares whenever a scheduled expectation is due
  always @(negedge clk) begin
    exp_t e;
    logic [13:0] act;
    act = {p1_up, p1_down, p2_up, p2_down, paused, serve, last_key};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.cyc != cyc || act !== e.exp) begin
        fails++;
        $display("FAIL v%0d: got %b_%h want %b_%h (cyc %0d/%0d)",
                 e.id, act[13:8], act[7:0], e.exp[13:8], e.exp[7:0],
                 cyc, e.cyc);
      end
    end
  end

  // exp = {p1_up,p1_down,p2_up,p2_down,paused,serve}
  task automatic drv(input logic r, input logic f, input logic b,
                     input logic [15:0] c, input logic [5:0] e,
                     input logic [7:0] k);
    exp_t x;
    @(posedge clk);
    #1;
    rst_b = r;
    finished = f;
    break_code = b;
    scan_code = c;
    x.cyc = cyc + 1;
    x.id = vid;
    x.exp = {e, k};
    sb.push_back(x);
    vid++;
  endtask

  initial begin
    // reset with a concurrent event
    drv(0, 1, 0, 16'hE027, 6'b000000, 8'h00);
    drv(0, 1, 0, 16'hE027, 6'b000000, 8'h00);
    drv(1, 0, 0, 16'h0000, 6'b000000, 8'h00);
    // p1 priority
    drv(1, 1, 0, 16'hE027, 6'b100000, 8'h27);
    drv(1, 1, 0, 16'hE01F, 6'b010000, 8'h1F);
    drv(1, 1, 1, 16'hE01F, 6'b100000, 8'h1F);
    drv(1, 1, 1, 16'hE027, 6'b000000, 8'h1F);
    // p2 typematic repeats
    for (int i = 0; i < 5; i++)
      drv(1, 1, 0, 16'hE075, 6'b001000, 8'h75);
    drv(1, 1, 0, 16'hE072, 6'b000100, 8'h72);
    drv(1, 1, 1, 16'hE075, 6'b000100, 8'h72);
    drv(1, 1, 1, 16'hE072, 6'b000000, 8'h72);
    // pri falls back to the remaining key
    drv(1, 1, 0, 16'hE075, 6'b001000, 8'h75);
    drv(1, 1, 0, 16'hE072, 6'b000100, 8'h72);
    drv(1, 1, 1, 16'hE072, 6'b001000, 8'h72);
    drv(1, 1, 1, 16'hE075, 6'b000000, 8'h72);
    // pause toggle
    drv(1, 1, 0, 16'hE027, 6'b100000, 8'h27);
    drv(1, 1, 0, 16'h004D, 6'b000010, 8'h4D);
    drv(1, 1, 0, 16'h004D, 6'b000010, 8'h4D);
    drv(1, 1, 1, 16'h004D, 6'b000010, 8'h4D);
    drv(1, 1, 0, 16'h004D, 6'b100000, 8'h4D);
    drv(1, 1, 1, 16'h004D, 6'b100000, 8'h4D);
    // serve pulse once per press
    drv(1, 1, 0, 16'h005A, 6'b100001, 8'h5A);
    drv(1, 1, 0, 16'h005A, 6'b100000, 8'h5A);
    drv(1, 1, 0, 16'h005A, 6'b100000, 8'h5A);
    drv(1, 1, 1, 16'h005A, 6'b100000, 8'h5A);
    // no serve while paused
    drv(1, 1, 0, 16'h004D, 6'b000010, 8'h4D);
    drv(1, 1, 1, 16'h004D, 6'b000010, 8'h4D);
    drv(1, 1, 0, 16'h005A, 6'b000010, 8'h5A);
    drv(1, 1, 1, 16'h005A, 6'b000010, 8'h5A);
    drv(1, 1, 0, 16'h004D, 6'b100000, 8'h4D);
    drv(1, 1, 1, 16'h004D, 6'b100000, 8'h4D);
    // unmatched codes ignored
    drv(1, 1, 0, 16'h0012, 6'b100000, 8'h4D);
    drv(1, 1, 0, 16'hE011, 6'b100000, 8'h4D);
    // players independent
    drv(1, 1, 0, 16'hE072, 6'b100100, 8'h72);
    drv(1, 1, 1, 16'hE072, 6'b100000, 8'h72);
    // idle: watchdog drops p1_up after 100 quiet cycles
    for (int i = 1; i <= 100; i++)
      drv(1, 0, 0, 16'h0000,
          (i == 100 && WD) ? 6'b000000 : 6'b100000, 8'h72);
    drv(1, 0, 0, 16'h0000, WD ? 6'b000000 : 6'b100000, 8'h72);
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
